// File: rtl/flag_unit_pkg.sv
// Shared ALU-op / condition-code encodings and flag-update helpers for the
// EX-stage flag unit.
package flag_pkg;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_ORR  = 3'b101;
  localparam logic [2:0] ALU_EOR  = 3'b110;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic op_sets_flags(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND);
  endfunction

  // Logical ops only produce N/Z; carry and overflow are forced clear.
  function automatic logic [3:0] next_flags(input logic [2:0] op,
                                            input logic n, input logic z,
                                            input logic c, input logic v);
    if (op == ALU_AND) return {n, z, 1'b0, 1'b0};
    return {n, z, c, v};
  endfunction

endpackage

// File: rtl/flag_unit_if.sv
// EX-stage bundle between the pipeline (master) and the flag unit (slave).
interface flag_unit_if #(
  parameter int NUM_FLAGS = 4,
  parameter int COND_W    = 4
);
  logic [2:0]           ALUCntrlO;
  logic                 FlagEO;
  logic                 alu_n;
  logic                 alu_z;
  logic                 alu_c;
  logic                 alu_v;
  logic                 stall;
  logic                 flush;
  logic                 br_req;
  logic [COND_W-1:0]    cond;
  logic [NUM_FLAGS-1:0] flags_q;
  logic                 flags_valid;
  logic                 take_branch;
  logic [7:0]           write_count;

  modport master (
    output ALUCntrlO, FlagEO, alu_n, alu_z, alu_c, alu_v,
           stall, flush, br_req, cond,
    input  flags_q, flags_valid, take_branch, write_count
  );

  modport slave (
    input  ALUCntrlO, FlagEO, alu_n, alu_z, alu_c, alu_v,
           stall, flush, br_req, cond,
    output flags_q, flags_valid, take_branch, write_count
  );
endinterface

// File: rtl/flag_unit_cond_eval.sv
// Combinational B.cond evaluator: condition code plus {N,Z,C,V} -> taken.
module cond_eval
  import flag_pkg::*;
#(
  parameter int NUM_FLAGS = 4,
  parameter int COND_W    = 4
) (
  input  logic [COND_W-1:0]    i_cond,
  input  logic [NUM_FLAGS-1:0] i_flags,
  output logic                 o_true
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_true = 1'b0;
    case (i_cond)
      COND_EQ: o_true = w_z;
      COND_NE: o_true = !w_z;
      COND_HS: o_true = w_c;
      COND_LO: o_true = !w_c;
      COND_MI: o_true = w_n;
      COND_PL: o_true = !w_n;
      COND_VS: o_true = w_v;
      COND_VC: o_true = !w_v;
      COND_HI: o_true = w_c && !w_z;
      COND_LS: o_true = !w_c || w_z;
      COND_GE: o_true = (w_n == w_v);
      COND_LT: o_true = (w_n != w_v);
      COND_GT: o_true = !w_z && (w_n == w_v);
      COND_LE: o_true = w_z || (w_n != w_v);
      COND_AL: o_true = 1'b1;
      COND_NV: o_true = 1'b1;
      default: o_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Architectural NZCV register with stall/flush-gated writes, a same-cycle
// bypass for branch evaluation, and a committed-write counter.
module flag_unit
  import flag_pkg::*;
#(
  parameter int NUM_FLAGS = 4,
  parameter int COND_W    = 4
) (
  input  logic      clk,
  input  logic      reset,
  flag_unit_if.slave bus
);

  logic [NUM_FLAGS-1:0] r_flags;
  logic                 r_valid;
  logic [7:0]           r_count;

  logic                 w_sets;
  logic                 w_fwd;
  logic                 w_we;
  logic [NUM_FLAGS-1:0] w_new;
  logic [NUM_FLAGS-1:0] w_eff;
  logic                 w_cond_true;

  assign w_sets = op_sets_flags(bus.ALUCntrlO);
  assign w_new  = next_flags(bus.ALUCntrlO, bus.alu_n, bus.alu_z,
                             bus.alu_c, bus.alu_v);

  // Bypass ignores stall so the branch decision is stable while EX is frozen.
  assign w_fwd  = bus.FlagEO && w_sets && !bus.flush;
  assign w_we   = w_fwd && !bus.stall;
  assign w_eff  = w_fwd ? w_new : r_flags;

  cond_eval #(
    .NUM_FLAGS (NUM_FLAGS),
    .COND_W    (COND_W)
  ) u_cond_eval (
    .i_cond  (bus.cond),
    .i_flags (w_eff),
    .o_true  (w_cond_true)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
      r_valid <= 1'b0;
      r_count <= 8'd0;
    end else if (w_we) begin
      r_flags <= w_new;
      r_valid <= 1'b1;
      r_count <= r_count + 8'd1;
    end
  end

  assign bus.flags_q     = r_flags;
  assign bus.flags_valid = r_valid;
  assign bus.write_count = r_count;
  assign bus.take_branch = bus.br_req && !bus.flush && w_cond_true;

endmodule

// File: tb/tb_flag_unit.sv
// Directed-vector bench for flag_unit with hand-computed expectations.
module tb_flag_unit;
  import flag_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  flag_unit_if #(.NUM_FLAGS(4), .COND_W(4)) bus ();

  flag_unit #(.NUM_FLAGS(4), .COND_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic fe, input logic [3:0] nzcv,
                       input logic st, input logic fl, input logic br, input logic [3:0] cc);
    bus.ALUCntrlO = op;
    bus.FlagEO    = fe;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = nzcv;
    bus.stall     = st;
    bus.flush     = fl;
    bus.br_req    = br;
    bus.cond      = cc;
    #1;
  endtask

  task automatic idle();
    drive(ALU_PASS, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, COND_EQ);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state and evaluation against zero flags
    chk("rst_flags", {28'd0, bus.flags_q}, 32'h0);
    chk("rst_valid", {31'd0, bus.flags_valid}, 32'h0);
    chk("rst_count", {24'd0, bus.write_count}, 32'h0);
    drive(ALU_PASS, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, COND_NE);
    chk("rst_ne", {31'd0, bus.take_branch}, 32'h1);
    drive(ALU_PASS, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, COND_EQ);
    chk("rst_eq", {31'd0, bus.take_branch}, 32'h0);

    // SUB with Z=1,C=1 and EQ branch in the same cycle: bypass
    drive(ALU_SUB, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, COND_EQ);
    chk("sub_bypass_eq", {31'd0, bus.take_branch}, 32'h1);
    chk("sub_pre_flags", {28'd0, bus.flags_q}, 32'h0);
    tick();
    idle();
    chk("sub_flags", {28'd0, bus.flags_q}, 32'h6);
    chk("sub_count", {24'd0, bus.write_count}, 32'h1);
    chk("sub_valid", {31'd0, bus.flags_valid}, 32'h1);

    // ADD to reach 0111, then AND with N=1,Z=0 clears C,V
    drive(ALU_ADD, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, COND_EQ);
    tick();
    idle();
    chk("add_flags", {28'd0, bus.flags_q}, 32'h7);
    drive(ALU_AND, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, COND_EQ);
    tick();
    idle();
    chk("and_flags", {28'd0, bus.flags_q}, 32'h8);
    chk("and_count", {24'd0, bus.write_count}, 32'h3);

    // ORR / EOR / pass-B / reserved with FlagEO: no write, no bypass
    drive(ALU_ORR, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, COND_MI);
    chk("orr_nobypass_mi", {31'd0, bus.take_branch}, 32'h1);
    drive(ALU_ORR, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, COND_GE);
    chk("orr_nobypass_ge", {31'd0, bus.take_branch}, 32'h0);
    tick();
    drive(ALU_EOR, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, COND_EQ);
    tick();
    drive(ALU_PASS, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, COND_EQ);
    tick();
    drive(3'b111, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, COND_EQ);
    tick();
    drive(3'b001, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, COND_EQ);
    tick();
    idle();
    chk("nowrite_flags", {28'd0, bus.flags_q}, 32'h8);
    chk("nowrite_count", {24'd0, bus.write_count}, 32'h3);

    // ADD held by a 3-cycle stall, bypass still visible
    drive(ALU_ADD, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, COND_VS);
    for (int i = 0; i < 3; i++) begin
      chk("stall_bypass_vs", {31'd0, bus.take_branch}, 32'h1);
      tick();
      chk("stall_flags", {28'd0, bus.flags_q}, 32'h8);
      chk("stall_count", {24'd0, bus.write_count}, 32'h3);
    end
    drive(ALU_ADD, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, COND_VS);
    tick();
    idle();
    chk("unstall_flags", {28'd0, bus.flags_q}, 32'h3);
    chk("unstall_count", {24'd0, bus.write_count}, 32'h4);

    // Flush squashes write and branch; stall+flush behaves as flush
    drive(ALU_SUB, 1'b1, 4'b1100, 1'b0, 1'b1, 1'b1, COND_AL);
    chk("flush_tb", {31'd0, bus.take_branch}, 32'h0);
    tick();
    chk("flush_count", {24'd0, bus.write_count}, 32'h4);
    drive(ALU_SUB, 1'b1, 4'b1100, 1'b1, 1'b1, 1'b1, COND_AL);
    chk("stflush_tb", {31'd0, bus.take_branch}, 32'h0);
    tick();
    idle();
    chk("stflush_count", {24'd0, bus.write_count}, 32'h4);
    chk("stflush_flags", {28'd0, bus.flags_q}, 32'h3);

    // Conditions against stored flags 0011 (C=1,V=1)
    drive(ALU_PASS, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, COND_AL);
    chk("nobr_al", {31'd0, bus.take_branch}, 32'h0);
    drive(ALU_PASS, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, COND_HI);
    chk("cc_hi", {31'd0, bus.take_branch}, 32'h1);
    drive(ALU_PASS, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, COND_LT);
    chk("cc_lt", {31'd0, bus.take_branch}, 32'h1);
    drive(ALU_PASS, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, COND_GT);
    chk("cc_gt", {31'd0, bus.take_branch}, 32'h0);
    drive(ALU_PASS, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, COND_LS);
    chk("cc_ls", {31'd0, bus.take_branch}, 32'h0);
    drive(ALU_PASS, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, COND_LO);
    chk("cc_lo", {31'd0, bus.take_branch}, 32'h0);
    drive(ALU_PASS, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, COND_NV);
    chk("cc_nv", {31'd0, bus.take_branch}, 32'h1);

    // 256 committed ADDs from a fresh reset wrap the counter to 0
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    drive(ALU_ADD, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, COND_EQ);
    for (int i = 0; i < 255; i++) tick();
    chk("wrap_255", {24'd0, bus.write_count}, 32'hFF);
    tick();
    chk("wrap_0", {24'd0, bus.write_count}, 32'h0);
    chk("wrap_valid", {31'd0, bus.flags_valid}, 32'h1);
    chk("wrap_flags", {28'd0, bus.flags_q}, 32'h5);

    // Reset wins over a simultaneous write
    drive(ALU_ADD, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, COND_EQ);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("rstw_flags", {28'd0, bus.flags_q}, 32'h0);
    chk("rstw_count", {24'd0, bus.write_count}, 32'h0);
    chk("rstw_valid", {31'd0, bus.flags_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
